// File: rtl/seg7_pkg.sv
// Shared constants and types for the scrolling seven-segment display controller.
// Segment patterns are active-low {a,b,c,d,e,f,g,dp}, with dp always off.
package seg7_pkg;

  localparam int NUM_DIGITS_DEFAULT = 8;

  localparam logic [4:0] CHAR_BLANK = 5'h10;
  localparam logic [4:0] CHAR_DASH  = 5'h11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1,
    8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational 5-bit character code to active-low segment pattern.
// Codes 0x00-0x0F are hex digits, 0x11 is a dash, everything else is blank.
module seg7_char_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!code[4]) begin
      seg = HEX_SEG[code[3:0]];
    end else if (code == CHAR_DASH) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Scrolling message controller for an 8-digit active-low seven-segment display:
// writable message buffer, start/stop scroll FSM and a free-running digit scanner.
module seg7_scroll_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEFAULT,
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 4096,
  parameter int SCROLL_DIV  = 4194304
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]            wr_addr,
  input  logic [4:0]                            wr_data,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  loop,
  output logic [NUM_DIGITS-1:0]                 select,
  output logic [7:0]                            display,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(MSG_LEN+NUM_DIGITS)-1:0] offset
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int OW = $clog2(MSG_LEN + NUM_DIGITS);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [OW-1:0] LAST_OFFSET = OW'(MSG_LEN + NUM_DIGITS - 1);
  localparam logic [SW-1:0] LAST_SCAN   = SW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] SCROLL_MAX  = CW'(SCROLL_DIV - 1);

  state_t        state;
  logic          loop_q;
  logic [CW-1:0] scroll_cnt;
  logic          scroll_tick;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_tick;
  logic [SW-1:0] scan;
  logic [SW-1:0] scan_nxt;
  logic [4:0]    msg [MSG_LEN];
  logic          addr_ok;
  int            frame_idx;
  logic [4:0]    frame_char;
  logic [7:0]    frame_seg;

  // Narrow address ports cannot exceed the buffer, so only check when they can.
  if ((1 << AW) > MSG_LEN) begin : g_addr_chk
    assign addr_ok = (int'(wr_addr) < MSG_LEN);
  end else begin : g_addr_all
    assign addr_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= CHAR_BLANK;
      end
    end else if (wr_en && addr_ok) begin
      msg[wr_addr] <= wr_data;
    end
  end

  assign scroll_tick = (state == RUN) && (scroll_cnt == SCROLL_MAX);

  // stop outranks start, and start outranks a coincident scroll tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      offset     <= '0;
      scroll_cnt <= '0;
      loop_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (stop) begin
      state      <= IDLE;
      scroll_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (start) begin
      state      <= RUN;
      offset     <= '0;
      scroll_cnt <= '0;
      loop_q     <= loop;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (scroll_tick) begin
            scroll_cnt <= '0;
            if (offset == LAST_OFFSET) begin
              if (loop_q) begin
                offset <= '0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              offset <= offset + 1'b1;
            end
          end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
          end
        end
        default: begin
          scroll_cnt <= '0;
        end
      endcase
    end
  end

  assign refresh_tick = (refresh_cnt == REFRESH_MAX);

  always_comb begin
    scan_nxt = scan;
    if (refresh_tick) begin
      scan_nxt = (scan == LAST_SCAN) ? '0 : scan + 1'b1;
    end
  end

  // Digit d at offset k shows msg[k-d]; anything outside the buffer is blank.
  always_comb begin
    frame_char = CHAR_BLANK;
    frame_idx  = int'(offset) - int'(scan_nxt);
    if (frame_idx >= 0 && frame_idx < MSG_LEN) begin
      frame_char = msg[frame_idx[AW-1:0]];
    end
  end

  seg7_char_decode u_decode (
    .code (frame_char),
    .seg  (frame_seg)
  );

  // select and display always load together so a digit never shows a stale pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan        <= '0;
      select      <= '1;
      display     <= SEG_BLANK;
    end else begin
      refresh_cnt <= refresh_tick ? '0 : refresh_cnt + 1'b1;
      scan        <= scan_nxt;
      if (state == IDLE) begin
        select  <= '1;
        display <= SEG_BLANK;
      end else if (refresh_tick) begin
        select  <= ~(NUM_DIGITS'(1) << scan_nxt);
        display <= frame_seg;
      end
    end
  end

endmodule
